uart_cmd_sequencer: RTL
=======================

// Module: uart_cmd_sequencer
// PURPOSE
//  Host-link command controller behind the UART receiver. Consumes the received byte stream
//  (byte + 1-cycle valid pulse), parses framed commands, and sequences byte writes into
//  SPC700 memory over a req/ack port. Also drives a CPU-hold line so the host can halt the
//  core while it loads RAM. Sits between the UART RX block and the memory arbiter.
// PARAMETERS
//  ADDR_W         16      memory address width
//  IDLE_TIMEOUT   400000  clocks with no byte mid-packet before the packet is aborted
//  TO_W           20      width of the timeout counter (must hold IDLE_TIMEOUT)
// PORTS
//  clock       in   1       system clock
//  reset       in   1       synchronous, active-high
//  rx_byte     in   8       received byte, valid while rx_ready is high
//  rx_ready    in   1       one-clock pulse per received byte
//  mem_req     out  1       write request; held until mem_ack
//  mem_addr    out  ADDR_W  write address, stable while mem_req is high
//  mem_wdata   out  8       write data, stable while mem_req is high
//  mem_ack     in   1       write accepted (sampled while mem_req is high)
//  cpu_hold    out  1       halt request to the SPC700 core
//  busy        out  1       high whenever the FSM is not in IDLE
//  cmd_done    out  1       one-clock pulse: command completed successfully
//  cmd_err     out  1       one-clock pulse: bad opcode, timeout or checksum fail
//  overrun     out  1       sticky: byte lost; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; skid register empty; address, length and timeout cleared.
//  Commands: 'W'(0x57) AH AL LEN D0..Dn writes LEN bytes (LEN=0 means 256) from {AH,AL} upward.
//   'H'(0x48) V sets cpu_hold<=V[0]. Any other opcode in IDLE -> cmd_err pulse; stay in IDLE.
//  FSM: IDLE -> ADDR_HI -> ADDR_LO -> LEN -> DATA <-> WRITE -> (CHECK) -> IDLE;
//   IDLE -> HOLD_ARG -> (CHECK) -> IDLE.
//  Byte intake: one-entry skid register, loaded on rx_ready. The FSM consumes from the skid
//   only in parse states, so a byte that arrives during WRITE waits in the skid.
//   rx_ready while the skid is full and not consumed that cycle -> overrun<=1; new byte dropped.
//   Same-cycle consume and load is legal: the skid stays full.
//  DATA: consume byte -> drive mem_addr/mem_wdata, mem_req<=1, go to WRITE.
//  WRITE: on mem_ack, mem_req<=0 the next edge; addr+1 (wraps modulo 2^ADDR_W); remaining-1.
//   If remaining reaches 0, the command ends; otherwise return to DATA. Back-to-back req is
//   therefore never shorter than 1 idle cycle.
//  Command end: cmd_done pulses 1 clock after the final ack (or 1 clock after the HOLD_ARG byte).
//  Timeout: counter cleared on each consumed byte and in IDLE; it counts in every non-IDLE
//   state except WRITE. Reaching IDLE_TIMEOUT -> cmd_err pulse, go to IDLE.
//  Reset mid-WRITE: mem_req drops on the reset edge; that transfer is abandoned.
//  Writes already acknowledged are never undone.
// CONFIGURATION
//  UART_CMD_CHECKSUM_EN defined: every command carries a trailing byte; CHECK state requires
//   8-bit sum(opcode..last byte incl. checksum)==0. Mismatch -> cmd_err instead of cmd_done.
//   Writes are already committed; for 'H', cpu_hold updates only on a passing checksum.
//  Undefined: no trailing byte; CHECK state absent; cmd_done follows directly.
// STRUCTURE
//  Shared package/header uart_cmd_defs: opcode constants (OP_WRITE, OP_HOLD), FSM state encodings.
//  One sub-module: uart_cmd_skid (1-entry byte buffer with overrun detect). Rest is inline.
// TESTING
//  1 'W' 12 34 02 AA BB, ack 1 clock after req -> writes 0x1234=AA, 0x1235=BB; one cmd_done.
//  2 'W' FF FF 02 01 02 -> writes 0xFFFF=01, 0x0000=02 (address wrap); cmd_done.
//  3 'H' 01 then 'H' 00 -> cpu_hold goes 1, then 0; two cmd_done pulses; no mem_req.
//  4 Opcode 0x00 -> cmd_err pulse, busy stays 0. 'W' 00 10 then silence IDLE_TIMEOUT clocks
//    -> cmd_err, back to IDLE, no mem_req.
//  5 Hold mem_ack low 3000 clocks during 'W' while 2 more bytes arrive -> overrun=1;
//    first queued byte is written next.
//  6 (CHECKSUM_EN) 'H' 01 B7 -> cpu_hold=1, cmd_done; 'H' 01 00 -> cmd_err, cpu_hold unchanged.

Source files
------------

// File: rtl/uart_cmd_defs_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_defs
// Shared definitions for the UART host-link command sequencer: opcode
// constants, the byte type used on the receive side and the FSM state
// encoding. The build macro UART_CMD_CHECKSUM_EN (see uart_cmd_sequencer)
// decides whether ST_CHECK is ever entered; the encoding is the same in
// both builds.
// ---------------------------------------------------------------------------
package uart_cmd_defs;

    typedef logic [7:0] byte_t;

    localparam byte_t OP_WRITE = 8'h57;  // 'W' AH AL LEN D0..Dn
    localparam byte_t OP_HOLD  = 8'h48;  // 'H' V

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_HI  = 3'd1,
        ST_ADDR_LO  = 3'd2,
        ST_LEN      = 3'd3,
        ST_DATA     = 3'd4,
        ST_WRITE    = 3'd5,
        ST_HOLD_ARG = 3'd6,
        ST_CHECK    = 3'd7
    } state_t;

    // A length byte of zero encodes a 256-byte transfer.
    function automatic logic [8:0] len_decode(input byte_t len_byte);
        return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/uart_cmd_skid.sv
// ---------------------------------------------------------------------------
// uart_cmd_skid
// One-entry byte buffer between the UART receiver and the command parser.
// A byte is captured on rx_ready; it stays until the parser consumes it.
// A byte arriving while the entry is occupied and not being consumed in
// the same cycle is dropped and the sticky overrun flag is raised.
//
// Ports
//   clock, reset : system clock, synchronous active-high reset
//   rx_byte      : received byte, valid with rx_ready
//   rx_ready     : one-cycle pulse per received byte
//   consume      : parser takes the buffered byte this cycle
//   full         : buffer holds an unconsumed byte
//   data         : buffered byte
//   overrun      : sticky, a byte was lost; cleared only by reset
// ---------------------------------------------------------------------------
module uart_cmd_skid
    import uart_cmd_defs::*;
(
    input  logic  clock,
    input  logic  reset,
    input  byte_t rx_byte,
    input  logic  rx_ready,
    input  logic  consume,
    output logic  full,
    output byte_t data,
    output logic  overrun
);

    always_ff @(posedge clock) begin
        if (reset) begin
            full    <= 1'b0;
            data    <= 8'd0;
            overrun <= 1'b0;
        end else if (rx_ready) begin
            if (full && !consume) begin
                // Occupied and not draining: the new byte is lost.
                overrun <= 1'b1;
            end else begin
                // Empty, or draining this cycle: the entry is refilled.
                data <= rx_byte;
                full <= 1'b1;
            end
        end else if (consume) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// uart_cmd_sequencer
// Host-link command controller behind the UART receiver. Parses framed
// commands from the received byte stream and sequences byte writes into
// SPC700 memory over a req/ack port; also drives the CPU-hold line.
//
//   'W' AH AL LEN D0..Dn : write LEN bytes (0 = 256) upward from {AH,AL}
//   'H' V                : cpu_hold <= V[0]
//
// Build option: define UART_CMD_CHECKSUM_EN to require a trailing checksum
// byte on every command (8-bit sum of all command bytes incl. checksum
// must be zero). Without it, commands end directly after their last byte.
//
// Ports
//   clock, reset   : system clock, synchronous active-high reset
//   rx_byte        : received byte, valid with rx_ready
//   rx_ready       : one-cycle pulse per received byte
//   mem_req        : write request, held until mem_ack
//   mem_addr       : write address, stable while mem_req is high
//   mem_wdata      : write data, stable while mem_req is high
//   mem_ack        : write accepted
//   cpu_hold       : halt request to the SPC700 core
//   busy           : FSM is not idle
//   cmd_done       : one-cycle pulse, command completed
//   cmd_err        : one-cycle pulse, bad opcode / timeout / checksum fail
//   overrun        : sticky, a received byte was lost
// ---------------------------------------------------------------------------
module uart_cmd_sequencer
    import uart_cmd_defs::*;
#(
    parameter int ADDR_W       = 16,
    parameter int IDLE_TIMEOUT = 400000,
    parameter int TO_W         = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    output logic              cpu_hold,
    output logic              busy,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic              overrun
);

    // Where a command goes once its payload is complete.
`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t ST_END = ST_CHECK;
`else
    localparam state_t ST_END = ST_IDLE;
`endif

    state_t            state;
    state_t            state_next;
    logic              skid_full;
    byte_t             skid_data;
    logic              consume;
    logic              timeout_hit;
    logic [TO_W-1:0]   to_cnt;
    logic [7:0]        addr_hi;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        remaining;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]        sum;
    logic              is_hold;
    logic              hold_arg;
`endif

    uart_cmd_skid u_skid (
        .clock    (clock),
        .reset    (reset),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .consume  (consume),
        .full     (skid_full),
        .data     (skid_data),
        .overrun  (overrun)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (consume) begin
                    if (skid_data == OP_WRITE)     state_next = ST_ADDR_HI;
                    else if (skid_data == OP_HOLD) state_next = ST_HOLD_ARG;
                end
            end
            ST_ADDR_HI:  if (consume) state_next = ST_ADDR_LO;
            ST_ADDR_LO:  if (consume) state_next = ST_LEN;
            ST_LEN:      if (consume) state_next = ST_DATA;
            ST_DATA:     if (consume) state_next = ST_WRITE;
            ST_WRITE: begin
                if (mem_ack) state_next = (remaining == 9'd1) ? ST_END : ST_DATA;
            end
            ST_HOLD_ARG: if (consume) state_next = ST_END;
            ST_CHECK:    if (consume) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
        if (timeout_hit) state_next = ST_IDLE;
    end

    // Output / control decode
    always_comb begin
        busy        = (state != ST_IDLE);
        // Every state except WRITE parses bytes, so a waiting byte is taken.
        consume     = skid_full && (state != ST_WRITE);
        // Fires on the cycle the idle counter would reach IDLE_TIMEOUT.
        timeout_hit = (state != ST_IDLE) && (state != ST_WRITE) && !skid_full &&
                      (to_cnt == TO_W'(IDLE_TIMEOUT - 1));
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            cpu_hold  <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
            to_cnt    <= '0;
            addr_hi   <= 8'd0;
            addr_q    <= '0;
            remaining <= 9'd0;
`ifdef UART_CMD_CHECKSUM_EN
            sum       <= 8'd0;
            is_hold   <= 1'b0;
            hold_arg  <= 1'b0;
`endif
        end else begin
            cmd_done <= 1'b0;
            cmd_err  <= timeout_hit;

            // The counter holds (rather than clears) during WRITE; it was
            // already cleared by the data byte that started the write.
            if (state == ST_IDLE || consume) to_cnt <= '0;
            else if (state != ST_WRITE)      to_cnt <= to_cnt + TO_W'(1);

`ifdef UART_CMD_CHECKSUM_EN
            if (consume) sum <= (state == ST_IDLE) ? skid_data : sum + skid_data;
`endif

            case (state)
                ST_IDLE: begin
                    if (consume) begin
                        if (skid_data != OP_WRITE && skid_data != OP_HOLD) cmd_err <= 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                        is_hold <= (skid_data == OP_HOLD);
`endif
                    end
                end
                ST_ADDR_HI: if (consume) addr_hi <= skid_data;
                ST_ADDR_LO: if (consume) addr_q <= ADDR_W'({addr_hi, skid_data});
                ST_LEN:     if (consume) remaining <= len_decode(skid_data);
                ST_DATA: begin
                    if (consume) begin
                        mem_addr  <= addr_q;
                        mem_wdata <= skid_data;
                        mem_req   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        addr_q    <= addr_q + ADDR_W'(1);
                        remaining <= remaining - 9'd1;
`ifndef UART_CMD_CHECKSUM_EN
                        if (remaining == 9'd1) cmd_done <= 1'b1;
`endif
                    end
                end
                ST_HOLD_ARG: begin
                    if (consume) begin
`ifdef UART_CMD_CHECKSUM_EN
                        // Applied only once the checksum passes.
                        hold_arg <= skid_data[0];
`else
                        cpu_hold <= skid_data[0];
                        cmd_done <= 1'b1;
`endif
                    end
                end
                ST_CHECK: begin
`ifdef UART_CMD_CHECKSUM_EN
                    if (consume) begin
                        if (8'(sum + skid_data) == 8'd0) begin
                            cmd_done <= 1'b1;
                            if (is_hold) cpu_hold <= hold_arg;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
